// File: rtl/parity_lane_pipe_if.sv
// Stream bundle for parity_lane_pipe: the input word handshake plus the registered result handshake.
// The master modport is the source/sink side and the slave modport is the pipe itself.
interface parity_lane_pipe_if #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANE_W*LANES-1:0]   in_data;
    logic [LANES-1:0]          in_par;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANE_W*LANES-1:0]   out_data;
    logic [LANES-1:0]          out_par;
    logic [LANES-1:0]          out_err;

    modport master (
        output in_valid, in_data, in_par, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_err
    );

    modport slave (
        input  in_valid, in_data, in_par, out_ready,
        output in_ready, out_valid, out_data, out_par, out_err
    );
endinterface

// File: rtl/parity_lane_pipe.sv
// Single-stage per-lane parity generator/checker with valid/ready handshake and error accounting.
// Optional one-shot error injection (inj_req port) is enabled by defining PARITY_ERR_INJECT_EN.
module parity_lane_pipe #(
    parameter int unsigned LANE_W      = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter bit          ODD_DEFAULT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_odd,
    input  logic                 cfg_check,
    input  logic                 err_clr,
`ifdef PARITY_ERR_INJECT_EN
    input  logic                 inj_req,
`endif
    parity_lane_pipe_if.slave    bus,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int unsigned DATA_W = LANE_W * LANES;

    logic              out_valid_q;
    logic [DATA_W-1:0] data_q;
    logic [LANES-1:0]  raw_q, raw_d;
    logic              odd_q;
    logic [LANES-1:0]  err_q, err_d;
    logic [LANES-1:0]  par_d;
    logic              sticky_q;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic              accept;
    logic              inj;

    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

`ifdef PARITY_ERR_INJECT_EN
    logic inj_q;

    assign inj = inj_q | inj_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= accept ? 1'b0 : inj;
        end
    end
`else
    assign inj = 1'b0;
`endif

    always_comb begin
        raw_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            raw_d[i] = ^bus.in_data[i*LANE_W +: LANE_W];
        end
        par_d = raw_d ^ {LANES{cfg_odd}};
        err_d = '0;
        if (cfg_check) begin
            err_d = bus.in_par ^ par_d;
            if (inj) begin
                err_d[0] = 1'b1;
            end
        end else if (inj) begin
            raw_d[0] = ~raw_d[0];
        end
    end

    // Parity is held as raw XOR plus the mode bit of the held word; reset preloads raw
    // with the default mode so the visible out_par still resets to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            raw_q       <= {LANES{ODD_DEFAULT}};
            odd_q       <= ODD_DEFAULT;
            err_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            data_q      <= bus.in_data;
            raw_q       <= raw_d;
            odd_q       <= cfg_odd;
            err_q       <= err_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept && (|err_d)) begin
            sticky_q <= 1'b1;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_par   = raw_q ^ {LANES{odd_q}};
    assign bus.out_err   = err_q;
    assign err_sticky    = sticky_q;
    assign err_cnt       = cnt_q;
endmodule

// File: tb/tb_parity_lane_pipe.sv
// Randomised and directed bench for parity_lane_pipe against a queue-free single-slot behavioural model.
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_parity_lane_pipe;
    logic        clk = 1'b0;
    logic        rst, cfg_odd, cfg_check, err_clr, inj_req;
    logic        err_sticky, sticky2;
    logic [15:0] err_cnt;
    logic [1:0]  cnt2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // behavioural model state
    bit          m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_par, m_err;
    bit          m_sticky, m_inj;
    int unsigned m_cnt;

    parity_lane_pipe_if #(.LANE_W(8), .LANES(4)) bus ();
    parity_lane_pipe_if #(.LANE_W(8), .LANES(4)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.in_par    = bus.in_par;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    parity_lane_pipe #(.LANE_W(8), .LANES(4), .ERR_CNT_W(16), .ODD_DEFAULT(1'b0)) dut (
        .clk(clk), .rst(rst), .cfg_odd(cfg_odd), .cfg_check(cfg_check), .err_clr(err_clr),
`ifdef PARITY_ERR_INJECT_EN
        .inj_req(inj_req),
`endif
        .bus(bus.slave), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    parity_lane_pipe #(.LANE_W(8), .LANES(4), .ERR_CNT_W(2), .ODD_DEFAULT(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .cfg_odd(cfg_odd), .cfg_check(cfg_check), .err_clr(err_clr),
`ifdef PARITY_ERR_INJECT_EN
        .inj_req(inj_req),
`endif
        .bus(bus2.slave), .err_sticky(sticky2), .err_cnt(cnt2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_par(input logic [31:0] d, input bit odd);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = (($countones(d[8*i +: 8]) % 2) == 1) ? !odd : odd;
        end
        return p;
    endfunction

    task automatic step(input bit r, input bit iv, input logic [31:0] d, input logic [3:0] p,
                        input bit odd, input bit chk, input bit ordy, input bit clr, input bit inj);
        bit acc;
        bit ie;
        logic [3:0] np, ne;
        rst = r; bus.in_valid = iv; bus.in_data = d; bus.in_par = p;
        cfg_odd = odd; cfg_check = chk; bus.out_ready = ordy; err_clr = clr; inj_req = inj;
        #1;
        if (!r) check_eq("in_ready", {63'd0, bus.in_ready}, {63'd0, (!m_valid || ordy)});
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = '0; m_par = '0; m_err = '0;
            m_sticky = 0; m_cnt = 0; m_inj = 0;
        end else begin
            acc = iv && (!m_valid || ordy);
            ie  = m_inj || inj;
            ne  = '0;
            if (acc) begin
                np = ref_par(d, odd);
                if (chk) ne = p ^ np;
                if (ie) begin
                    if (chk) ne[0] = 1'b1;
                    else     np[0] = ~np[0];
                end
                m_data = d; m_par = np; m_err = ne; m_valid = 1;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (clr) begin
                m_cnt = 0; m_sticky = 0;
            end else if (acc && ne != 4'b0) begin
                m_cnt++; m_sticky = 1;
            end
            m_inj = acc ? 1'b0 : ie;
        end
        #1;
        check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
        if (m_valid || r) begin
            check_eq("out_data", {32'd0, bus.out_data}, {32'd0, m_data});
            check_eq("out_par",  {60'd0, bus.out_par},  {60'd0, m_par});
            check_eq("out_err",  {60'd0, bus.out_err},  {60'd0, m_err});
        end
        check_eq("err_sticky", {63'd0, err_sticky}, {63'd0, m_sticky});
        check_eq("err_cnt",  {48'd0, err_cnt}, (m_cnt > 65535) ? 64'd65535 : 64'(m_cnt));
        check_eq("err_cnt_sat", {62'd0, cnt2}, (m_cnt > 3) ? 64'd3 : 64'(m_cnt));
    endtask

    initial begin
        logic [31:0] w;
        bit          pinj;
        rst = 1'b1; cfg_odd = 1'b0; cfg_check = 1'b0; err_clr = 1'b0; inj_req = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_par = '0; bus.out_ready = 1'b0;
        m_valid = 0; m_data = '0; m_par = '0; m_err = '0; m_sticky = 0; m_inj = 0; m_cnt = 0;

        // reset overrides a handshake presented in the same cycle
        step(1, 1, 32'hDEAD_BEEF, 4'hF, 0, 1, 1, 0, 0);
        step(1, 1, 32'h1234_5678, 4'h0, 1, 0, 1, 0, 0);
        check_eq("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("rst_cnt",   {48'd0, err_cnt}, 64'd0);

        step(0, 1, 32'hFF55_0100, 4'h0, 0, 0, 1, 0, 0);
        check_eq("gen_even_par", {60'd0, bus.out_par}, 64'b0010);
        check_eq("gen_even_err", {60'd0, bus.out_err}, 64'd0);
        step(0, 1, 32'hFF55_0100, 4'h0, 1, 0, 1, 0, 0);
        check_eq("gen_odd_par", {60'd0, bus.out_par}, 64'b1101);
        step(0, 1, 32'h0000_0001, 4'h0, 0, 1, 1, 0, 0);
        check_eq("chk_err", {60'd0, bus.out_err}, 64'b0001);
        check_eq("chk_sticky", {63'd0, err_sticky}, 64'd1);
        check_eq("chk_cnt", {48'd0, err_cnt}, 64'd1);
        step(0, 0, 32'h0, 4'h0, 0, 0, 1, 1, 0);
        check_eq("clr_cnt", {48'd0, err_cnt}, 64'd0);
        check_eq("clr_sticky", {63'd0, err_sticky}, 64'd0);

        // backpressure: hold one word, change mode mid-stall, then drain in order
        step(0, 1, 32'hA5A5_0F0F, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h0102_0304, 4'hF, i[0], 1, 0, 0, 0);
            check_eq("stall_ready", {63'd0, bus.in_ready}, 64'd0);
            check_eq("stall_data", {32'd0, bus.out_data}, 64'hA5A5_0F0F);
        end
        step(0, 1, 32'h0102_0304, 4'h0, 0, 0, 1, 0, 0);
        check_eq("drain_next", {32'd0, bus.out_data}, 64'h0102_0304);
        step(0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 16; i++) step(0, 1, $urandom, 4'h0, 0, 0, 1, 0, 0);
        step(0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0);

        // saturation of the 2-bit counter
        step(0, 0, 32'h0, 4'h0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 32'h0000_0001, 4'h0, 0, 1, 1, 0, 0);
        check_eq("sat_cnt2", {62'd0, cnt2}, 64'd3);
        check_eq("sat_cnt16", {48'd0, err_cnt}, 64'd5);
        step(0, 1, 32'h0000_0100, 4'h0, 0, 1, 1, 0, 0);
        check_eq("sat_hold", {62'd0, cnt2}, 64'd3);

        // clear wins over an erroring accept
        step(0, 1, 32'h0000_0001, 4'h0, 0, 1, 1, 1, 0);
        check_eq("clr_wins_cnt", {48'd0, err_cnt}, 64'd0);
        check_eq("clr_wins_sticky", {63'd0, err_sticky}, 64'd0);

        // reset while stalled discards the held word
        step(0, 1, 32'h7777_7777, 4'h0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h8888_8888, 4'h0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h8888_8888, 4'h0, 0, 0, 0, 0, 0);
        check_eq("rst_stall_valid", {63'd0, bus.out_valid}, 64'd0);

`ifdef PARITY_ERR_INJECT_EN
        step(0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 1);
        step(0, 1, 32'h0, 4'h0, 0, 0, 1, 0, 0);
        check_eq("inj_par", {60'd0, bus.out_par}, 64'b0001);
        step(0, 1, 32'h0, 4'h0, 0, 0, 1, 0, 0);
        check_eq("inj_oneshot", {60'd0, bus.out_par}, 64'b0000);
`endif

        for (int i = 0; i < 600; i++) begin
            w = $urandom;
`ifdef PARITY_ERR_INJECT_EN
            pinj = ($urandom_range(0, 15) == 0);
`else
            pinj = 1'b0;
`endif
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), w,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), pinj);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/parity_lane_pipe.md
Name: parity_lane_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational parity generator.
- Splits each DATA_W-bit word into LANES lanes of LANE_W bits and processes every lane in one of two modes:
  - Generate mode: computes a parity bit per lane.
  - Check mode: compares a supplied parity vector against the computed one and flags mismatches.
- One registered stage with valid/ready handshake.
- Keeps a sticky error flag and a saturating error counter.
- Sits between a byte-stream source and a link/memory interface.

Parameters:
- LANE_W, 8, bits per parity lane.
- LANES, 4, number of lanes; DATA_W = LANE_W*LANES.
- ERR_CNT_W, 16, width of the saturating error counter.
- ODD_DEFAULT, 0, reset value of the internal odd/even mode bit (0 = even parity).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- cfg_odd  in  1  1 = odd parity, 0 = even; sampled with each accepted word.
- cfg_check  in  1  0 = generate mode, 1 = check mode; sampled with each accepted word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  LANE_W*LANES  data word.
- in_par  in  LANES  supplied parity bits (check mode only; ignored in generate mode).
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANE_W*LANES  registered copy of in_data.
- out_par  out  LANES  computed parity per lane (generate and check modes).
- out_err  out  LANES  per-lane mismatch mask (check mode); all zero in generate mode.
- err_sticky  out  1  set on any lane mismatch; cleared only by err_clr or rst.
- err_clr  in  1  synchronous clear of err_sticky and err_cnt.
- err_cnt  out  ERR_CNT_W  count of accepted words with at least one lane error; saturates.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_par=0, out_err=0, err_sticky=0, err_cnt=0.
  - rst overrides every other input, including a handshake in the same cycle.
- Lane parity: lane i = in_data[i*LANE_W +: LANE_W].
  - Even mode: par[i] = XOR of the lane bits. Odd mode: par[i] = ~XOR.
  - Example: lane 8'h01 gives par=1 even, par=0 odd.
- in_ready = ~out_valid | out_ready. Combinational; no registered path from in_valid to in_ready.
- Accept condition: in_valid & in_ready.
  - On accept, the next edge loads out_data, out_par and out_err, and sets out_valid=1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Drain: out_valid & out_ready with no new accept clears out_valid at the next edge. The out_* values hold their last content and are don't-care.
- Simultaneous drain and accept: the register is reloaded and out_valid stays 1. Full throughput is 1 word/cycle.
- Stall: out_valid & ~out_ready gives in_ready=0. out_data, out_par and out_err must stay stable until the handshake.
- Mode: cfg_odd and cfg_check apply only to the accepted word. Changing them mid-stall does not alter a held result.
- Check mode: out_err[i] = in_par[i] ^ computed_par[i].
- Error accounting happens on the accept edge (not on drain) when |out_err_next.
  - err_sticky is set to 1.
  - err_cnt increments by 1, saturating at 2^ERR_CNT_W-1; it never wraps.
- err_clr=1 in the same cycle as an erroring accept: the clear wins. Result is err_cnt=0 and err_sticky=0.
- Reset mid-stall: the held word is discarded and out_valid=0 at the next edge.

Optional Feature:
- Macro: PARITY_ERR_INJECT_EN.
- When defined, the block adds input port inj_req (1 bit).
  - A pulse arms a one-shot flag.
  - The next accepted word has out_par[0] inverted (generate mode), or is treated as a lane-0 mismatch (check mode, which also increments err_cnt).
  - The flag clears on that accept.
  - If inj_req and the accept coincide, the injection applies to that word.
  - rst clears the flag.
- When undefined, the port is absent and behaviour is exactly as above.

Test Plan:
- Reset then generate-even with LANES=4, LANE_W=8:
  - in_data=32'hFF55_0100 -> out_par=4'b0010 one cycle later, out_err=0, err_cnt=0.
- Generate-odd with the same word -> out_par=4'b1101.
- Check-even with in_data=32'h0000_0001 and in_par=4'b0000:
  - out_err=4'b0001, err_sticky=1, err_cnt=1.
  - err_clr pulse -> err_cnt=0, err_sticky=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout.
  - Release -> words drain in order with no loss or duplication.
  - Back-to-back stream of 16 words with out_ready=1 -> 16 outputs on 16 consecutive cycles.
- Saturation with ERR_CNT_W=2: 5 erroring words -> err_cnt=3 and stays 3.
- PARITY_ERR_INJECT_EN defined: inj_req pulse, then generate-even 32'h0 -> out_par=4'b0001; the next word has out_par=4'b0000.
